uart_rx_packet_parser: RTL and testbench

UART_RX_PACKET_PARSER -- requirements
Module: uart_rx_packet_parser

---
 rtl/uart_rx_packet_parser.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_packet_parser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_parser.sv
// uart_rx_packet_parser
// Frames bytes from an upstream UART receiver into packets of the form
// SYNC, CMD, LEN, payload[LEN], CHK where CHK is the XOR of CMD, LEN and
// every payload byte. A verified packet is held until the consumer acks it.
// Errors abort the current frame and raise a one-cycle strobe with a code.
module uart_rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Pkt_Ack,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic       o_Pkt_Valid,
  output logic [7:0] o_Pkt_Cmd,
  output logic [4:0] o_Pkt_Len,
  output logic       o_Err_Pulse,
  output logic [1:0] o_Err_Code
);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_DATA,
    GET_CHK,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'b00,
    ERR_BAD_LEN = 2'b01,
    ERR_CHKSUM  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam logic [4:0]  MAX_LEN_W   = 5'(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CLKS - 1);

  state_e      state_q;
  logic [7:0]  cmd_q;
  logic [4:0]  len_q;
  logic [7:0]  chk_q;
  logic [3:0]  idx_q;
  logic [15:0] tmo_q;
  logic        pkt_valid_q;
  logic        err_pulse_q;
  err_e        err_code_q;
  // The buffer is always 16 deep so the 4-bit read index never runs past
  // the array; entries at or above MAX_LEN are never written and read as 0.
  logic [7:0]  buf_q [16];

  // Frame parser, payload buffer, timeout counter and registered outputs.
  // NOTE: state is updated with non-blocking assignments only, so every
  // branch below sees the values from the start of the cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      pkt_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_OVERRUN;
      // NOTE: the payload buffer is deliberately cleared on reset so a
      // consumer never reads contents left over from before the reset.
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      err_pulse_q <= 1'b0;

      // Inter-byte timer: only runs while a frame is in progress.
      if (i_RX_DV || state_q == IDLE || state_q == HOLD) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          if (i_RX_DV && i_RX_Byte == SYNC_BYTE) begin
            state_q <= GET_CMD;
          end
        end

        HOLD: begin
          // Bytes arriving while a packet is held are dropped, even when
          // the ack lands on the same cycle.
          if (i_RX_DV) begin
            err_pulse_q <= 1'b1;
            err_code_q  <= ERR_OVERRUN;
          end
          if (i_Pkt_Ack) begin
            pkt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          if (i_RX_DV) begin
            case (state_q)
              GET_CMD: begin
                cmd_q   <= i_RX_Byte;
                chk_q   <= i_RX_Byte;
                state_q <= GET_LEN;
              end
              GET_LEN: begin
                chk_q <= chk_q ^ i_RX_Byte;
                idx_q <= '0;
                if (i_RX_Byte > MAX_LEN_B) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_BAD_LEN;
                  state_q     <= IDLE;
                end else begin
                  len_q   <= i_RX_Byte[4:0];
                  state_q <= (i_RX_Byte == 8'd0) ? GET_CHK : GET_DATA;
                end
              end
              GET_DATA: begin
                buf_q[idx_q] <= i_RX_Byte;
                chk_q        <= chk_q ^ i_RX_Byte;
                idx_q        <= idx_q + 4'd1;
                if ({1'b0, idx_q} == len_q - 5'd1) begin
                  state_q <= GET_CHK;
                end
              end
              GET_CHK: begin
                if (i_RX_Byte == chk_q) begin
                  pkt_valid_q <= 1'b1;
                  state_q     <= HOLD;
                end else begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_CHKSUM;
                  state_q     <= IDLE;
                end
              end
              default: state_q <= IDLE;
            endcase
          end else if (tmo_q == TMO_LAST) begin
            // A strobe on this same cycle takes the branch above instead.
            err_pulse_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            tmo_q       <= '0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  // Combinational payload read port; out-of-range addresses read as zero.
  always_comb begin
    o_Rd_Data = 8'h00;
    if ({1'b0, i_Rd_Addr} < MAX_LEN_W) begin
      o_Rd_Data = buf_q[i_Rd_Addr];
    end
  end

  assign o_Pkt_Valid = pkt_valid_q;
  assign o_Pkt_Cmd   = cmd_q;
  assign o_Pkt_Len   = len_q;
  assign o_Err_Pulse = err_pulse_q;
  assign o_Err_Code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Directed testbench for uart_rx_packet_parser. Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the active rising edge.
module tb_uart_rx_packet_parser;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       pkt_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [7:0] pkt_cmd;
  logic [4:0] pkt_len;
  logic       err_pulse;
  logic [1:0] err_code;

  int total = 0;
  int passed = 0;
  int err_cnt = 0;
  int err_base;

  uart_rx_packet_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (8),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_RX_DV    (rx_dv),
    .i_RX_Byte  (rx_byte),
    .i_Pkt_Ack  (pkt_ack),
    .i_Rd_Addr  (rd_addr),
    .o_Rd_Data  (rd_data),
    .o_Pkt_Valid(pkt_valid),
    .o_Pkt_Cmd  (pkt_cmd),
    .o_Pkt_Len  (pkt_len),
    .o_Err_Pulse(err_pulse),
    .o_Err_Code (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge and tally any error strobe seen there.
  task automatic tick();
    @(negedge clk);
    if (err_pulse === 1'b1) err_cnt++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
  endtask

  initial begin
    // Reset state.
    tick(); tick();
    check("rst_valid", {31'd0, pkt_valid}, 32'd0);
    check("rst_cmd", {24'd0, pkt_cmd}, 32'd0);
    check("rst_len", {27'd0, pkt_len}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    rd_check("rst_rd0", 4'd0, 8'h00);
    rst_n = 1'b1;
    tick();

    // Good 3-byte frame, then ack.
    err_base = err_cnt;
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    check("good_valid", {31'd0, pkt_valid}, 32'd1);
    check("good_cmd", {24'd0, pkt_cmd}, 32'h10);
    check("good_len", {27'd0, pkt_len}, 32'd3);
    rd_check("good_rd0", 4'd0, 8'h11);
    rd_check("good_rd1", 4'd1, 8'h22);
    rd_check("good_rd2", 4'd2, 8'h33);
    rd_check("good_rd3_stale", 4'd3, 8'h00);
    rd_check("good_rd8_oob", 4'd8, 8'h00);
    check("good_no_err", err_cnt - err_base, 32'd0);
    tick();
    check("good_still_valid", {31'd0, pkt_valid}, 32'd1);
    ack();
    check("good_ack_clears", {31'd0, pkt_valid}, 32'd0);

    // Bad checksum, then zero-length frame.
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14});
    check("chk_err_pulse", {31'd0, err_pulse}, 32'd1);
    check("chk_err_code", {30'd0, err_code}, 32'd2);
    check("chk_no_valid", {31'd0, pkt_valid}, 32'd0);
    tick();
    check("chk_pulse_one_cycle", {31'd0, err_pulse}, 32'd0);
    check("chk_code_held", {30'd0, err_code}, 32'd2);
    send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
    check("len0_valid", {31'd0, pkt_valid}, 32'd1);
    check("len0_cmd", {24'd0, pkt_cmd}, 32'h20);
    check("len0_len", {27'd0, pkt_len}, 32'd0);
    rd_check("len0_rd0_stale", 4'd0, 8'h11);
    ack();

    // Junk byte ignored, then oversize length.
    err_base = err_cnt;
    send(8'h55);
    check("junk_silent", err_cnt - err_base, 32'd0);
    send_seq('{8'hA5, 8'h01, 8'h09});
    check("badlen_pulse", {31'd0, err_pulse}, 32'd1);
    check("badlen_code", {30'd0, err_code}, 32'd1);
    send_seq('{8'hA5, 8'h40, 8'h01, 8'h77, 8'h36});
    check("after_badlen_valid", {31'd0, pkt_valid}, 32'd1);
    check("after_badlen_cmd", {24'd0, pkt_cmd}, 32'h40);
    rd_check("after_badlen_rd0", 4'd0, 8'h77);
    ack();

    // Maximum length frame.
    send_seq('{8'hA5, 8'h01, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08,
               8'h10, 8'h20, 8'h40, 8'h80, 8'hF6});
    check("maxlen_valid", {31'd0, pkt_valid}, 32'd1);
    check("maxlen_len", {27'd0, pkt_len}, 32'd8);
    rd_check("maxlen_rd7", 4'd7, 8'h80);
    rd_check("maxlen_rd8_oob", 4'd8, 8'h00);
    ack();

    // Inter-byte timeout mid-payload.
    send_seq('{8'hA5, 8'h10, 8'h02, 8'hAA});
    repeat (TMO - 1) tick();
    check("tmo_not_early", {31'd0, err_pulse}, 32'd0);
    tick();
    check("tmo_pulse", {31'd0, err_pulse}, 32'd1);
    check("tmo_code", {30'd0, err_code}, 32'd3);
    send_seq('{8'hA5, 8'h30, 8'h01, 8'h5A, 8'h6B});
    check("after_tmo_valid", {31'd0, pkt_valid}, 32'd1);
    rd_check("after_tmo_rd0", 4'd0, 8'h5A);
    ack();

    // Overrun while holding, then ack coinciding with a byte.
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    send(8'h77);
    check("ovr_pulse", {31'd0, err_pulse}, 32'd1);
    check("ovr_code", {30'd0, err_code}, 32'd0);
    check("ovr_valid_kept", {31'd0, pkt_valid}, 32'd1);
    check("ovr_cmd_kept", {24'd0, pkt_cmd}, 32'h10);
    check("ovr_len_kept", {27'd0, pkt_len}, 32'd3);
    rd_check("ovr_rd1_kept", 4'd1, 8'h22);
    tick();
    pkt_ack = 1'b1;
    rx_dv   = 1'b1;
    rx_byte = 8'hA5;
    tick();
    pkt_ack = 1'b0;
    rx_dv   = 1'b0;
    check("ackbyte_pulse", {31'd0, err_pulse}, 32'd1);
    check("ackbyte_code", {30'd0, err_code}, 32'd0);
    check("ackbyte_valid", {31'd0, pkt_valid}, 32'd0);
    ack();
    send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
    check("ackbyte_idle_valid", {31'd0, pkt_valid}, 32'd1);
    check("ackbyte_idle_cmd", {24'd0, pkt_cmd}, 32'h20);
    ack();

    // Reset mid-frame.
    send_seq('{8'hA5, 8'h01, 8'h09});
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
    err_base = err_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, pkt_valid}, 32'd0);
    check("midrst_cmd", {24'd0, pkt_cmd}, 32'd0);
    check("midrst_len", {27'd0, pkt_len}, 32'd0);
    check("midrst_code", {30'd0, err_code}, 32'd0);
    rd_check("midrst_rd0", 4'd0, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_err", err_cnt - err_base, 32'd0);
    send_seq('{8'hA5, 8'h30, 8'h01, 8'h5A, 8'h6B});
    check("postrst_valid", {31'd0, pkt_valid}, 32'd1);
    check("postrst_cmd", {24'd0, pkt_cmd}, 32'h30);
    rd_check("postrst_rd0", 4'd0, 8'h5A);
    check("postrst_no_err", err_cnt - err_base, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
